// File: rtl/axi_line_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_line_master_pkg
//  Purpose  : Shared AXI encodings, FSM state codes and sizing helper for
//             the cache line master.
//  Revision : 1.0  initial release
// ============================================================================
package axi_line_master_pkg;

  // AXI burst / response encodings
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Master FSM state codes
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AW   = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;
  localparam logic [2:0] ST_AR   = 3'd4;
  localparam logic [2:0] ST_R    = 3'd5;

  // Ceiling log2, usable in constant expressions
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_line_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi_line_master
//  Purpose  : AXI4 master for cache line traffic. A refill is one INCR read
//             burst, a dirty-line writeback is one INCR write burst. One
//             transaction in flight, fixed ID 0, line-aligned addresses.
//  Revision : 1.0  initial release
// ============================================================================
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_LINE_WORDS       = 4
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       rst,
  // cache refill side
  input  logic                                       rd_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]              rd_addr,
  output logic                                       rd_ack,
  output logic                                       rd_beat_vld,
  output logic [C_M_AXI_DATA_WIDTH-1:0]              rd_beat_data,
  output logic [clogb2(C_LINE_WORDS)-1:0]            rd_beat_idx,
  output logic                                       rd_done,
  // cache writeback side
  input  logic                                       wr_req,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]              wr_addr,
  input  logic [C_LINE_WORDS*C_M_AXI_DATA_WIDTH-1:0] wr_line,
  output logic                                       wr_ack,
  output logic                                       wr_done,
  output logic                                       bus_err,
  // AXI write address
  output logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
  output logic [7:0]                                 M_AXI_AWLEN,
  output logic [2:0]                                 M_AXI_AWSIZE,
  output logic [1:0]                                 M_AXI_AWBURST,
  output logic                                       M_AXI_AWLOCK,
  output logic [3:0]                                 M_AXI_AWCACHE,
  output logic [2:0]                                 M_AXI_AWPROT,
  output logic [3:0]                                 M_AXI_AWQOS,
  output logic [3:0]                                 M_AXI_AWREGION,
  output logic                                       M_AXI_AWVALID,
  input  logic                                       M_AXI_AWREADY,
  // AXI write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
  output logic                                       M_AXI_WLAST,
  output logic                                       M_AXI_WVALID,
  input  logic                                       M_AXI_WREADY,
  // AXI write response
  input  logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_BID,
  input  logic [1:0]                                 M_AXI_BRESP,
  input  logic                                       M_AXI_BVALID,
  output logic                                       M_AXI_BREADY,
  // AXI read address
  output logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
  output logic [7:0]                                 M_AXI_ARLEN,
  output logic [2:0]                                 M_AXI_ARSIZE,
  output logic [1:0]                                 M_AXI_ARBURST,
  output logic                                       M_AXI_ARLOCK,
  output logic [3:0]                                 M_AXI_ARCACHE,
  output logic [2:0]                                 M_AXI_ARPROT,
  output logic [3:0]                                 M_AXI_ARQOS,
  output logic [3:0]                                 M_AXI_ARREGION,
  output logic                                       M_AXI_ARVALID,
  input  logic                                       M_AXI_ARREADY,
  // AXI read data
  input  logic [C_M_AXI_ID_WIDTH-1:0]                M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
  input  logic [1:0]                                 M_AXI_RRESP,
  input  logic                                       M_AXI_RLAST,
  input  logic                                       M_AXI_RVALID,
  output logic                                       M_AXI_RREADY
);

  localparam int C_BYTES    = C_M_AXI_DATA_WIDTH / 8;
  localparam int C_IDX_W    = clogb2(C_LINE_WORDS);
  localparam int C_OFF_BITS = clogb2(C_LINE_WORDS * C_BYTES);

  localparam logic [7:0]             C_LEN       = 8'(C_LINE_WORDS - 1);
  localparam logic [2:0]             C_SIZE      = 3'(clogb2(C_BYTES));
  localparam logic [C_IDX_W-1:0]     C_IDX_LAST  = C_IDX_W'(C_LINE_WORDS - 1);
  localparam logic [C_IDX_W-1:0]     C_IDX_ONE   = C_IDX_W'(1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] C_ADDR_MASK =
    ~(C_M_AXI_ADDR_WIDTH'((1 << C_OFF_BITS) - 1));

  logic [2:0]                    state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_IDX_W-1:0]            beat_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] line_q [C_LINE_WORDS];
  logic                          rd_done_q;
  logic                          bus_err_q;

  logic idle_free, accept_wr, accept_rd;
  logic w_hs, r_hs, b_hs, last_beat;

  // Response IDs are not checked: only one transaction is ever in flight.
  logic unused_ids;
  assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

  // Request acceptance and channel handshake decode
  always_comb begin
    // No accept while rd_done is pulsing, so a request in that cycle waits one cycle.
    idle_free = (state_q == ST_IDLE) && !rst && !rd_done_q;
    accept_wr = idle_free && wr_req;
    accept_rd = idle_free && rd_req && !wr_req;
    w_hs      = (state_q == ST_W) && M_AXI_WREADY;
    r_hs      = (state_q == ST_R) && M_AXI_RVALID;
    b_hs      = (state_q == ST_B) && M_AXI_BVALID;
    last_beat = (beat_q == C_IDX_LAST);
  end

  // FSM state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_wr)      state_d = ST_AW;
        else if (accept_rd) state_d = ST_AR;
      end
      ST_AW:   if (M_AXI_AWREADY)          state_d = ST_W;
      ST_W:    if (w_hs && last_beat)      state_d = ST_B;
      ST_B:    if (M_AXI_BVALID)           state_d = ST_IDLE;
      ST_AR:   if (M_AXI_ARREADY)          state_d = ST_R;
      // Read burst ends on RLAST even when it arrives at the wrong beat.
      ST_R:    if (r_hs && M_AXI_RLAST)    state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Address latch, beat counter, done pulse and sticky error flag
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      addr_q    <= '0;
      beat_q    <= '0;
      rd_done_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rd_done_q <= r_hs && M_AXI_RLAST;
      if (accept_wr || accept_rd) begin
        addr_q <= (accept_wr ? wr_addr : rd_addr) & C_ADDR_MASK;
        beat_q <= '0;
      end else if (w_hs || r_hs) begin
        beat_q <= beat_q + C_IDX_ONE;
      end
      if (r_hs && ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != last_beat)))
        bus_err_q <= 1'b1;
      if (b_hs && (M_AXI_BRESP != AXI_RESP_OKAY))
        bus_err_q <= 1'b1;
    end
  end

  // Writeback line capture; the cache may reuse wr_line after wr_ack
  always_ff @(posedge S_AXI_ACLK) begin
    if (accept_wr) begin
      for (int i = 0; i < C_LINE_WORDS; i++)
        line_q[i] <= wr_line[i*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
    end
  end

  // FSM outputs; payloads are zero outside their own phase
  always_comb begin
    rd_ack         = 1'b0;
    wr_ack         = 1'b0;
    rd_beat_vld    = 1'b0;
    rd_beat_data   = '0;
    rd_beat_idx    = '0;
    wr_done        = 1'b0;
    M_AXI_AWID     = '0;
    M_AXI_AWADDR   = '0;
    M_AXI_AWLEN    = '0;
    M_AXI_AWSIZE   = '0;
    M_AXI_AWBURST  = '0;
    M_AXI_AWLOCK   = 1'b0;
    M_AXI_AWCACHE  = '0;
    M_AXI_AWPROT   = '0;
    M_AXI_AWQOS    = '0;
    M_AXI_AWREGION = '0;
    M_AXI_AWVALID  = 1'b0;
    M_AXI_WDATA    = '0;
    M_AXI_WSTRB    = '0;
    M_AXI_WLAST    = 1'b0;
    M_AXI_WVALID   = 1'b0;
    M_AXI_BREADY   = 1'b0;
    M_AXI_ARID     = '0;
    M_AXI_ARADDR   = '0;
    M_AXI_ARLEN    = '0;
    M_AXI_ARSIZE   = '0;
    M_AXI_ARBURST  = '0;
    M_AXI_ARLOCK   = 1'b0;
    M_AXI_ARCACHE  = '0;
    M_AXI_ARPROT   = '0;
    M_AXI_ARQOS    = '0;
    M_AXI_ARREGION = '0;
    M_AXI_ARVALID  = 1'b0;
    M_AXI_RREADY   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ack = accept_rd;
        wr_ack = accept_wr;
      end
      ST_AW: begin
        M_AXI_AWVALID = 1'b1;
        M_AXI_AWADDR  = addr_q;
        M_AXI_AWLEN   = C_LEN;
        M_AXI_AWSIZE  = C_SIZE;
        M_AXI_AWBURST = AXI_BURST_INCR;
      end
      ST_W: begin
        // Only reachable after the AW handshake, so W never precedes AW.
        M_AXI_WVALID = 1'b1;
        M_AXI_WDATA  = line_q[beat_q];
        M_AXI_WSTRB  = '1;
        M_AXI_WLAST  = last_beat;
      end
      ST_B: begin
        M_AXI_BREADY = 1'b1;
        wr_done      = M_AXI_BVALID;
      end
      ST_AR: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = addr_q;
        M_AXI_ARLEN   = C_LEN;
        M_AXI_ARSIZE  = C_SIZE;
        M_AXI_ARBURST = AXI_BURST_INCR;
      end
      ST_R: begin
        M_AXI_RREADY = 1'b1;
        rd_beat_vld  = M_AXI_RVALID;
        rd_beat_data = M_AXI_RDATA;
        rd_beat_idx  = beat_q;
      end
      default: ;
    endcase
  end

  assign rd_done = rd_done_q;
  assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_line_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_line_master
//  Purpose  : Directed self-checking bench for axi_line_master; the bench
//             plays the RAM slave with a word-array memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_line_master;
  import axi_line_master_pkg::*;

  logic         clk;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_ack;
  logic         rd_beat_vld;
  logic [31:0]  rd_beat_data;
  logic [1:0]   rd_beat_idx;
  logic         rd_done;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_line;
  logic         wr_ack;
  logic         wr_done;
  logic         bus_err;

  logic [0:0]  AWID;    logic [31:0] AWADDR; logic [7:0] AWLEN;  logic [2:0] AWSIZE;
  logic [1:0]  AWBURST; logic        AWLOCK; logic [3:0] AWCACHE; logic [2:0] AWPROT;
  logic [3:0]  AWQOS;   logic [3:0]  AWREGION; logic AWVALID; logic AWREADY;
  logic [31:0] WDATA;   logic [3:0]  WSTRB;  logic WLAST; logic WVALID; logic WREADY;
  logic [0:0]  BID;     logic [1:0]  BRESP;  logic BVALID; logic BREADY;
  logic [0:0]  ARID;    logic [31:0] ARADDR; logic [7:0] ARLEN;  logic [2:0] ARSIZE;
  logic [1:0]  ARBURST; logic        ARLOCK; logic [3:0] ARCACHE; logic [2:0] ARPROT;
  logic [3:0]  ARQOS;   logic [3:0]  ARREGION; logic ARVALID; logic ARREADY;
  logic [0:0]  RID;     logic [31:0] RDATA;  logic [1:0] RRESP; logic RLAST;
  logic        RVALID;  logic        RREADY;

  logic [31:0] mem [0:63];
  int n_pass;
  int n_total;

  axi_line_master #(
    .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32), .C_LINE_WORDS(4)
  ) dut (
    .S_AXI_ACLK(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_beat_vld(rd_beat_vld), .rd_beat_data(rd_beat_data),
    .rd_beat_idx(rd_beat_idx), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line),
    .wr_ack(wr_ack), .wr_done(wr_done), .bus_err(bus_err),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
    .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS),
    .M_AXI_AWREGION(AWREGION), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN),
    .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK),
    .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT), .M_AXI_ARQOS(ARQOS),
    .M_AXI_ARREGION(ARREGION), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Status/handshake outputs that must all be low when nothing is active
  function automatic logic [10:0] ctl_vec();
    return {AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_ack, wr_ack,
            rd_done, wr_done, rd_beat_vld, bus_err};
  endfunction

  task automatic write_line(input logic [31:0] addr, input logic [127:0] line,
                            input int aw_wait, input bit throttle, input bit req_given);
    logic [31:0] base;
    int b;
    base = addr & ~32'hF;
    if (!req_given) begin
      @(negedge clk); wr_req = 1'b1; wr_addr = addr; wr_line = line; #1;
      chk("wr_ack", wr_ack, 1);
    end
    @(negedge clk); wr_req = 1'b0; wr_line = '0; #1;
    chk("aw_valid", AWVALID, 1);
    chk("aw_addr", AWADDR, base);
    chk("aw_len", AWLEN, 3);
    chk("aw_size", AWSIZE, 2);
    chk("aw_burst", AWBURST, 1);
    chk("w_before_aw", WVALID, 0);
    chk("rd_ack_busy", rd_ack, 0);
    for (int i = 0; i < aw_wait; i++) begin
      @(negedge clk); #1;
      chk("aw_hold_valid", AWVALID, 1);
      chk("aw_hold_addr", AWADDR, base);
      chk("aw_hold_len", AWLEN, 3);
      chk("w_before_aw_wait", WVALID, 0);
    end
    AWREADY = 1'b1;
    @(negedge clk); AWREADY = 1'b0;
    b = 0;
    for (int cyc = 0; cyc < 16 && b < 4; cyc++) begin
      WREADY = throttle ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("w_valid", WVALID, 1);
      chk("w_data", WDATA, line[b*32 +: 32]);
      chk("w_strb", WSTRB, 4'hF);
      chk("w_last", WLAST, (b == 3));
      chk("ar_during_w", ARVALID, 0);
      if (WVALID && WREADY) begin
        mem[(base >> 2) + b] = line[b*32 +: 32];
        b++;
      end
      @(negedge clk); WREADY = 1'b0;
    end
    chk("w_beat_count", b, 4);
    #1;
    chk("w_off_in_b", WVALID, 0);
    chk("b_ready", BREADY, 1);
    chk("wr_done_early", wr_done, 0);
    BVALID = 1'b1; BRESP = AXI_RESP_OKAY; #1;
    chk("wr_done", wr_done, 1);
    @(negedge clk); BVALID = 1'b0; #1;
    chk("wr_done_pulse", wr_done, 0);
    chk("b_ready_off", BREADY, 0);
  endtask

  task automatic read_line(input logic [31:0] addr, input int err_beat,
                           input bit req_given, input bit exp_err);
    logic [31:0] base;
    base = addr & ~32'hF;
    if (!req_given) begin
      @(negedge clk); rd_req = 1'b1; rd_addr = addr; #1;
      chk("rd_ack", rd_ack, 1);
      chk("wr_ack_on_rd", wr_ack, 0);
    end
    @(negedge clk); rd_req = 1'b0; #1;
    chk("ar_valid", ARVALID, 1);
    chk("ar_addr", ARADDR, base);
    chk("ar_len", ARLEN, 3);
    chk("ar_size", ARSIZE, 2);
    chk("ar_burst", ARBURST, 1);
    chk("rd_ack_pulse", rd_ack, 0);
    chk("r_ready_in_ar", RREADY, 0);
    ARREADY = 1'b1;
    @(negedge clk); ARREADY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      RVALID = 1'b1;
      RDATA  = mem[(base >> 2) + b];
      RRESP  = (b == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      RLAST  = (b == 3);
      #1;
      chk("r_ready", RREADY, 1);
      chk("r_beat_vld", rd_beat_vld, 1);
      chk("r_beat_idx", rd_beat_idx, b);
      chk("r_beat_data", rd_beat_data, mem[(base >> 2) + b]);
      chk("rd_done_early", rd_done, 0);
      chk("ar_off_in_r", ARVALID, 0);
      @(negedge clk);
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = AXI_RESP_OKAY; RDATA = '0; #1;
    chk("rd_done", rd_done, 1);
    chk("r_ready_off", RREADY, 0);
    chk("bus_err", bus_err, exp_err);
    @(negedge clk); #1;
    chk("rd_done_pulse", rd_done, 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_line = '0;
    AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0;
    ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h24010001; mem[1] = 32'h00011100;
    mem[2] = 32'h00411821; mem[3] = 32'h00022082;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", ctl_vec(), 0);
    chk("reset_araddr", ARADDR, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_ctl", ctl_vec(), 0);

    // 1. Refill of an unaligned address
    read_line(32'h0000000C, -1, 1'b0, 1'b0);

    // 2. Writeback to 0x40, then refill the same line
    write_line(32'h00000040, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000},
               0, 1'b0, 1'b0);
    chk("mem_model_40", mem[16], 32'hAAAA0000);
    read_line(32'h00000040, -1, 1'b0, 1'b0);

    // 3. Simultaneous requests: write first, refill only after wr_done
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 32'h20;
    wr_line = {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000};
    rd_req = 1'b1; rd_addr = 32'h24;
    #1;
    chk("both_wr_ack", wr_ack, 1);
    chk("both_rd_ack", rd_ack, 0);
    write_line(32'h20, {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000},
               0, 1'b0, 1'b1);
    chk("rd_ack_after_wdone", rd_ack, 1);
    read_line(32'h24, -1, 1'b1, 1'b0);

    // 4. Throttled AWREADY and WREADY
    write_line(32'h0000008C, {32'hF00D0004, 32'hCAFE0003, 32'hBEEF0002, 32'hDEAD0001},
               3, 1'b1, 1'b0);
    read_line(32'h00000080, -1, 1'b0, 1'b0);

    // 5. SLVERR on beat 2, then sticky across a clean refill
    read_line(32'h00000000, 2, 1'b0, 1'b1);
    read_line(32'h00000040, -1, 1'b0, 1'b1);

    // 6. Reset in the middle of a refill burst
    @(negedge clk); rd_req = 1'b1; rd_addr = 32'h0; #1;
    chk("r6_ack", rd_ack, 1);
    @(negedge clk); rd_req = 1'b0; ARREADY = 1'b1; #1;
    chk("r6_arvalid", ARVALID, 1);
    @(negedge clk); ARREADY = 1'b0; RVALID = 1'b1; RDATA = mem[0]; RLAST = 1'b0; #1;
    chk("r6_idx0", rd_beat_idx, 0);
    @(negedge clk); RDATA = mem[1]; rst = 1'b1; #1;
    chk("r6_idx1", rd_beat_idx, 1);
    @(negedge clk); rst = 1'b0; RVALID = 1'b0; RDATA = '0; #1;
    chk("r6_post_reset_ctl", ctl_vec(), 0);
    read_line(32'h00000004, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
